// File: rtl/l1_mem_arbiter_if.sv
// Valid/ready memory-port bundle shared by L1 requesters and main memory.
// master drives the request fields; slave answers with ready/rdata.
interface l1_mem_arbiter_if #(
    parameter int ADDR_W = 9
) ();
    logic              valid;
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              ready;
    logic [31:0]       rdata;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between two L1 caches.
// Grants are held until memory answers or the watchdog error-completes.
module l1_mem_arbiter #(
    parameter int          ADDR_W   = 9,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic clk,
    input  logic reset,
    l1_mem_arbiter_if.slave  req0,
    l1_mem_arbiter_if.slave  req1,
    l1_mem_arbiter_if.master mem,
    output logic grant_id,
    output logic busy,
    output logic timeout_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              mv_q, mv_d;
    logic              instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       rd0_q, rd0_d;
    logic [31:0]       rd1_q, rd1_d;
    logic              rdy0_q, rdy0_d;
    logic              rdy1_q, rdy1_d;
    logic              terr_q, terr_d;
    logic              busy_q, busy_d;
    logic              pick;

    // Next-state logic: arbitrate in IDLE, watch memory in BUSY, pulse in RESP.
    always_comb begin
        state_d = state_q;
        mv_d    = mv_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        terr_d  = 1'b0;
        busy_d  = busy_q;
        pick    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req0.valid || req1.valid) begin
                    pick    = (req0.valid && req1.valid) ? ~last_q : req1.valid;
                    grant_d = pick;
                    instr_d = pick ? req1.instr : req0.instr;
                    addr_d  = pick ? req1.addr  : req0.addr;
                    wdata_d = pick ? req1.wdata : req0.wdata;
                    wstrb_d = pick ? req1.wstrb : req0.wstrb;
                    mv_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (mem.ready || cnt_q == CNT_LAST) begin
                    if (grant_q) begin
                        rd1_d  = mem.ready ? mem.rdata : ERR_DATA;
                        rdy1_d = 1'b1;
                    end else begin
                        rd0_d  = mem.ready ? mem.rdata : ERR_DATA;
                        rdy0_d = 1'b1;
                    end
                    terr_d  = ~mem.ready;
                    mv_d    = 1'b0;
                    last_d  = grant_q;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                mv_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            mv_q    <= 1'b0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mv_q    <= mv_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            terr_q  <= terr_d;
            busy_q  <= busy_d;
        end
    end

    assign mem.valid   = mv_q;
    assign mem.instr   = instr_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;
    assign mem.wstrb   = wstrb_q;
    assign req0.ready  = rdy0_q;
    assign req0.rdata  = rd0_q;
    assign req1.ready  = rdy1_q;
    assign req1.rdata  = rd1_q;
    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter with a small behavioural memory.
// Each task drives one scenario and checks hand-computed values inline.
module tb_l1_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_mem_arbiter_if #(.ADDR_W(9)) req0_if ();
    l1_mem_arbiter_if #(.ADDR_W(9)) req1_if ();
    l1_mem_arbiter_if #(.ADDR_W(9)) mem_if ();
    logic grant_id, busy, timeout_err;

    l1_mem_arbiter #(
        .ADDR_W(9), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk), .reset(rst),
        .req0(req0_if), .req1(req1_if), .mem(mem_if),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] marr [0:127];
    logic        mdl_ready;
    logic [31:0] mdl_rdata;
    int          vcnt;
    bit          mute;
    int          delay;
    logic        pulse_ready;
    logic        pv0, pv1;

    assign mem_if.ready = mdl_ready | pulse_ready;
    assign mem_if.rdata = pulse_ready ? 32'h0BADF00D : mdl_rdata;

    // Memory model: answers after 'delay' sampled valid cycles unless muted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_ready <= 1'b0;
            mdl_rdata <= '0;
            vcnt      <= 0;
        end else if (mem_if.valid && !mdl_ready && !mute) begin
            if (vcnt + 1 >= delay) begin
                mdl_ready <= 1'b1;
                vcnt      <= 0;
                mdl_rdata <= marr[mem_if.addr[8:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_if.wstrb[b])
                        marr[mem_if.addr[8:2]][8*b +: 8] <= mem_if.wdata[8*b +: 8];
            end else begin
                vcnt <= vcnt + 1;
            end
        end else begin
            mdl_ready <= 1'b0;
            if (!mem_if.valid) vcnt <= 0;
        end
    end

    // Requester protocol monitor: valid must not fall before ready.
    always @(posedge clk) begin
        if (!rst && pv0 && !req0_if.valid && !req0_if.ready) begin
            checks++;
            $display("FAIL proto0 valid dropped before ready");
        end
        if (!rst && pv1 && !req1_if.valid && !req1_if.ready) begin
            checks++;
            $display("FAIL proto1 valid dropped before ready");
        end
        pv0 <= req0_if.valid;
        pv1 <= req1_if.valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [8:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (n == 0) begin
            req0_if.valid = v; req0_if.instr = 1'b0; req0_if.addr = a;
            req0_if.wdata = d; req0_if.wstrb = s;
        end else begin
            req1_if.valid = v; req1_if.instr = 1'b0; req1_if.addr = a;
            req1_if.wdata = d; req1_if.wstrb = s;
        end
    endtask

    task automatic wait_any(output int who, output bit ok);
        ok  = 1'b0;
        who = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (req0_if.ready || req1_if.ready) begin
                ok  = 1'b1;
                who = req1_if.ready ? 1 : 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (mem_if.valid !== 1'b0) $display("FAIL rst_mv got=%b exp=0", mem_if.valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passes++;
        checks++; if (grant_id !== 1'b0) $display("FAIL rst_gid got=%b exp=0", grant_id); else passes++;
        checks++; if ({req0_if.ready, req1_if.ready, timeout_err} !== 3'b000)
            $display("FAIL rst_pulses got=%b exp=000", {req0_if.ready, req1_if.ready, timeout_err}); else passes++;
        checks++; if (req0_if.rdata !== 32'h0) $display("FAIL rst_rd0 got=%h exp=0", req0_if.rdata); else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        marr[2] = 32'h0000a103;
        set_req(0, 1'b1, 9'h008, 32'h0, 4'h0);
        req0_if.instr = 1'b1;
        checks++; if (mem_if.valid !== 1'b0) $display("FAIL sr_mv0 got=%b exp=0", mem_if.valid); else passes++;
        tick();
        checks++; if (mem_if.valid !== 1'b1) $display("FAIL sr_mv1 got=%b exp=1", mem_if.valid); else passes++;
        checks++; if (mem_if.addr !== 9'h008) $display("FAIL sr_addr got=%h exp=008", mem_if.addr); else passes++;
        checks++; if (mem_if.instr !== 1'b1) $display("FAIL sr_instr got=%b exp=1", mem_if.instr); else passes++;
        tick();
        checks++; if (req0_if.ready !== 1'b0) $display("FAIL sr_early got=%b exp=0", req0_if.ready); else passes++;
        tick();
        checks++; if (req0_if.ready !== 1'b1) $display("FAIL sr_rdy got=%b exp=1", req0_if.ready); else passes++;
        checks++; if (req0_if.rdata !== 32'h0000a103) $display("FAIL sr_rdata got=%h exp=0000a103", req0_if.rdata); else passes++;
        checks++; if (req1_if.ready !== 1'b0) $display("FAIL sr_rdy1 got=%b exp=0", req1_if.ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL sr_busy got=%b exp=1", busy); else passes++;
        req0_if.valid = 1'b0;
        tick();
        checks++; if (req0_if.ready !== 1'b0) $display("FAIL sr_pulse got=%b exp=0", req0_if.ready); else passes++;
        checks++; if (req0_if.rdata !== 32'h0000a103) $display("FAIL sr_hold got=%h exp=0000a103", req0_if.rdata); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL sr_idle got=%b exp=0", busy); else passes++;
    endtask

    task automatic test_write_forward();
        int who; bit ok;
        set_req(1, 1'b1, 9'h0FC, 32'h12345678, 4'hF);
        tick();
        checks++; if (mem_if.addr !== 9'h0FC) $display("FAIL wf_addr got=%h exp=0fc", mem_if.addr); else passes++;
        checks++; if (mem_if.wdata !== 32'h12345678) $display("FAIL wf_wdata got=%h exp=12345678", mem_if.wdata); else passes++;
        checks++; if (mem_if.wstrb !== 4'hF) $display("FAIL wf_wstrb got=%h exp=f", mem_if.wstrb); else passes++;
        checks++; if (grant_id !== 1'b1) $display("FAIL wf_gid got=%b exp=1", grant_id); else passes++;
        wait_any(who, ok);
        checks++; if (!ok || who != 1) $display("FAIL wf_rdy got=%0d exp=1", who); else passes++;
        req1_if.valid = 1'b0;
        tick();
        set_req(0, 1'b1, 9'h0FC, 32'h0, 4'h0);
        wait_any(who, ok);
        checks++; if (!ok || who != 0) $display("FAIL wf_rb_rdy got=%0d exp=0", who); else passes++;
        checks++; if (req0_if.rdata !== 32'h12345678) $display("FAIL wf_rb got=%h exp=12345678", req0_if.rdata); else passes++;
        checks++; if (req1_if.rdata === 32'h12345678) $display("FAIL wf_rd1 got=%h exp=untouched", req1_if.rdata); else passes++;
        req0_if.valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int hc = 0; bit done = 1'b0;
        mute = 1'b1;
        set_req(0, 1'b1, 9'h010, 32'h0, 4'h0);
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (mem_if.valid) hc++; else done = 1'b1;
        end
        checks++; if (!done || hc != 16) $display("FAIL to_len got=%0d exp=16", hc); else passes++;
        checks++; if (req0_if.ready !== 1'b1) $display("FAIL to_rdy got=%b exp=1", req0_if.ready); else passes++;
        checks++; if (req0_if.rdata !== 32'hDEADBEEF) $display("FAIL to_rdata got=%h exp=deadbeef", req0_if.rdata); else passes++;
        checks++; if (timeout_err !== 1'b1) $display("FAIL to_err got=%b exp=1", timeout_err); else passes++;
        checks++; if (req1_if.ready !== 1'b0) $display("FAIL to_rdy1 got=%b exp=0", req1_if.ready); else passes++;
        req0_if.valid = 1'b0;
        tick();
        checks++; if ({timeout_err, req0_if.ready} !== 2'b00)
            $display("FAIL to_pulse got=%b exp=00", {timeout_err, req0_if.ready}); else passes++;
        tick();
        tick();
        pulse_ready = 1'b1;
        tick();
        pulse_ready = 1'b0;
        checks++; if ({busy, mem_if.valid, req0_if.ready, req1_if.ready, timeout_err} !== 5'b0)
            $display("FAIL to_late got=%b exp=00000",
                     {busy, mem_if.valid, req0_if.ready, req1_if.ready, timeout_err}); else passes++;
        checks++; if (req0_if.rdata !== 32'hDEADBEEF) $display("FAIL to_late_rd got=%h exp=deadbeef", req0_if.rdata); else passes++;
        mute = 1'b0;
    endtask

    task automatic test_ready_last();
        int hc = 0; bit done = 1'b0;
        marr[4] = 32'hA5A5A5A5;
        delay = 15;
        set_req(0, 1'b1, 9'h010, 32'h0, 4'h0);
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (mem_if.valid) hc++; else done = 1'b1;
        end
        checks++; if (!done || hc != 16) $display("FAIL rl_len got=%0d exp=16", hc); else passes++;
        checks++; if (req0_if.ready !== 1'b1) $display("FAIL rl_rdy got=%b exp=1", req0_if.ready); else passes++;
        checks++; if (req0_if.rdata !== 32'hA5A5A5A5) $display("FAIL rl_rdata got=%h exp=a5a5a5a5", req0_if.rdata); else passes++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL rl_err got=%b exp=0", timeout_err); else passes++;
        req0_if.valid = 1'b0;
        delay = 1;
        tick();
    endtask

    task automatic test_contention();
        int who; bit ok; int exp = 0;
        do_reset();
        marr[8]  = 32'h00000111;
        marr[16] = 32'h00000222;
        set_req(0, 1'b1, 9'h020, 32'h0, 4'h0);
        set_req(1, 1'b1, 9'h040, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            wait_any(who, ok);
            checks++; if (!ok || who != exp || grant_id !== exp[0])
                $display("FAIL ct_order%0d got=%0d/%b exp=%0d", k, who, grant_id, exp); else passes++;
            if (k == 0) begin
                checks++; if (req0_if.rdata !== 32'h111) $display("FAIL ct_rd0 got=%h exp=111", req0_if.rdata); else passes++;
            end
            if (k == 1) begin
                checks++; if (req1_if.rdata !== 32'h222) $display("FAIL ct_rd1 got=%h exp=222", req1_if.rdata); else passes++;
            end
            if (who == 1) req1_if.valid = 1'b0; else req0_if.valid = 1'b0;
            tick();
            if (k < 6) begin
                if (who == 1) req1_if.valid = 1'b1; else req0_if.valid = 1'b1;
            end
            exp = 1 - exp;
        end
        req0_if.valid = 1'b0;
        req1_if.valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int who; bit ok;
        set_req(0, 1'b1, 9'h008, 32'h0, 4'h0);
        wait_any(who, ok);
        req0_if.valid = 1'b0;
        tick();
        mute = 1'b1;
        set_req(1, 1'b1, 9'h040, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        checks++; if (busy !== 1'b1) $display("FAIL rm_busy_pre got=%b exp=1", busy); else passes++;
        #2;
        rst = 1'b1;
        req1_if.valid = 1'b0;
        #1;
        checks++; if ({mem_if.valid, busy, req0_if.ready, req1_if.ready} !== 4'b0)
            $display("FAIL rm_clear got=%b exp=0000",
                     {mem_if.valid, busy, req0_if.ready, req1_if.ready}); else passes++;
        @(posedge clk); #1;
        rst  = 1'b0;
        mute = 1'b0;
        set_req(0, 1'b1, 9'h020, 32'h0, 4'h0);
        set_req(1, 1'b1, 9'h040, 32'h0, 4'h0);
        wait_any(who, ok);
        checks++; if (!ok || who != 0 || grant_id !== 1'b0)
            $display("FAIL rm_first got=%0d/%b exp=0", who, grant_id); else passes++;
        req0_if.valid = 1'b0;
        wait_any(who, ok);
        checks++; if (!ok || who != 1) $display("FAIL rm_second got=%0d exp=1", who); else passes++;
        req1_if.valid = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) marr[i] = 32'h0;
        mute = 1'b0;
        delay = 1;
        pulse_ready = 1'b0;
        pv0 = 1'b0;
        pv1 = 1'b0;
        set_req(0, 1'b0, 9'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 9'h0, 32'h0, 4'h0);
        test_reset();
        test_single_read();
        test_write_forward();
        test_timeout();
        test_ready_last();
        test_contention();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
